// File: rtl/pi2bpsk_seq.sv
// pi/2-BPSK symbol sequencer: turns a counted stream of coded bits into
// phase indices (units of 2*pi/CYC_DIV) alternating between the two rotated constellations.
module pi2bpsk_seq #(
  parameter int CYC_DIV = 24,
  parameter int LEN_W   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  output logic             o_bit_ready,
  output logic             o_sym_valid,
  output logic [4:0]       o_cyc_part,
  output logic             o_sym_last,
  input  logic             i_sym_ready,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Odd multiples of an eighth-cycle: even symbols use 1/8 and 5/8, odd ones 3/8 and 7/8.
  localparam logic [4:0] P_B0_EVEN = 5'(CYC_DIV / 8);
  localparam logic [4:0] P_B0_ODD  = 5'((3 * CYC_DIV) / 8);
  localparam logic [4:0] P_B1_EVEN = 5'((5 * CYC_DIV) / 8);
  localparam logic [4:0] P_B1_ODD  = 5'((7 * CYC_DIV) / 8);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_remain;
  logic [LEN_W-1:0] r_index;
  logic             r_sym_valid;
  logic             r_sym_last;
  logic [4:0]       r_cyc_part;
  logic [4:0]       w_phase;
  logic             w_abort;
  logic             w_bit_xfer;
  logic             w_sym_xfer;
  logic             w_last_bit;

  assign w_abort     = i_abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign o_bit_ready = (r_state == S_RUN) && (!r_sym_valid || i_sym_ready);
  // An abort wins over any handshake that happens to complete in the same cycle.
  assign w_bit_xfer  = i_bit_valid && o_bit_ready && !w_abort;
  assign w_sym_xfer  = r_sym_valid && i_sym_ready && !w_abort;
  assign w_last_bit  = (r_remain == LEN_W'(1));

  assign o_sym_valid = r_sym_valid;
  assign o_sym_last  = r_sym_last;
  assign o_cyc_part  = r_cyc_part;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

  always_comb begin
    w_phase = P_B0_EVEN;
    case ({i_bit, r_index[0]})
      2'b00:   w_phase = P_B0_EVEN;
      2'b01:   w_phase = P_B0_ODD;
      2'b10:   w_phase = P_B1_EVEN;
      default: w_phase = P_B1_ODD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_abort)                      w_next = S_IDLE;
        else if (w_bit_xfer && w_last_bit) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_abort)                       w_next = S_IDLE;
        else if (w_sym_xfer && r_sym_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_remain    <= '0;
      r_index     <= '0;
      r_sym_valid <= 1'b0;
      r_sym_last  <= 1'b0;
      r_cyc_part  <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_remain <= i_len;
        r_index  <= '0;
      end else if (w_bit_xfer) begin
        r_remain <= r_remain - LEN_W'(1);
        r_index  <= r_index + LEN_W'(1);
      end

      // A new bit refills the output register even while the old symbol leaves.
      if (w_abort) begin
        r_sym_valid <= 1'b0;
        r_sym_last  <= 1'b0;
      end else if (w_bit_xfer) begin
        r_sym_valid <= 1'b1;
        r_cyc_part  <= w_phase;
        r_sym_last  <= w_last_bit;
      end else if (w_sym_xfer) begin
        r_sym_valid <= 1'b0;
        r_sym_last  <= 1'b0;
      end
    end
  end

endmodule
